// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer: mode encodings, FSM states and
// the default tuning-word width.
package dds_pkg;

    localparam int unsigned DEFAULT_W = 8;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_FIXED  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDwell,
        StWaitWrap,
        StHold,
        StDone
    } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: counts tick pulses while enabled and pulses expired on the dwell-th one.
// A programmed dwell of zero behaves as a dwell of one tick.
module dds_dwell_timer #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          tick,
    input  logic [DW-1:0] dwell,
    output logic          expired
);

    logic [DW-1:0] cnt_q, cnt_d, target;

    // cnt_q never exceeds target-1, so the increment cannot overflow.
    always_comb begin
        target  = (dwell == '0) ? DW'(1) : dwell;
        expired = !clr && tick && ((cnt_q + DW'(1)) == target);
        if (clr || expired) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + DW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word between start and stop values,
// committing each new word only on a phase-accumulator wrap.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned W  = DEFAULT_W,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          phase_wrap,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  k_start,
    input  logic [W-1:0]  k_stop,
    input  logic [W-1:0]  step,
    input  logic [DW-1:0] dwell,
    output logic [W-1:0]  k_out,
    output logic          k_valid,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic          fixed_q, fixed_d;
    logic [W-1:0]  k_start_q, k_start_d, k_stop_q, k_stop_d, step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [W-1:0]  k_out_q, k_out_d, k_pend_q, k_pend_d;
    logic          dir_down_q, dir_down_d;
    logic          k_valid_q, k_valid_d, cfg_err_q, cfg_err_d;
    logic          expired, cfg_bad, at_stop, at_start;
    logic [W:0]    up_sum, down_lim;
    logic [W-1:0]  up_next, down_next;

    dds_dwell_timer #(
        .DW(DW)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != StDwell),
        .tick   (tick),
        .dwell  (dwell_q),
        .expired(expired)
    );

    // Extra bit keeps the clamp decisions exact near the top of the word range.
    always_comb begin
        up_sum    = {1'b0, k_out_q} + {1'b0, step_q};
        up_next   = (up_sum >= {1'b0, k_stop_q}) ? k_stop_q : up_sum[W-1:0];
        down_lim  = {1'b0, k_start_q} + {1'b0, step_q};
        down_next = ({1'b0, k_out_q} < down_lim) ? k_start_q : k_out_q - step_q;
        at_stop   = (k_out_q == k_stop_q);
        at_start  = (k_out_q == k_start_q);
        cfg_bad   = (mode != MODE_FIXED) && ((k_stop <= k_start) || (step == '0));
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        fixed_d    = fixed_q;
        k_start_d  = k_start_q;
        k_stop_d   = k_stop_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        k_out_d    = k_out_q;
        k_pend_d   = k_pend_q;
        dir_down_d = dir_down_q;
        k_valid_d  = 1'b0;
        cfg_err_d  = 1'b0;
        if (stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        mode_d     = mode;
                        fixed_d    = (mode == MODE_FIXED) || cfg_bad;
                        k_start_d  = k_start;
                        k_stop_d   = k_stop;
                        step_d     = step;
                        dwell_d    = dwell;
                        dir_down_d = 1'b0;
                        k_out_d    = k_start;
                        k_valid_d  = 1'b1;
                        cfg_err_d  = cfg_bad;
                        state_d    = StLoad;
                    end
                end
                StLoad: state_d = fixed_q ? StHold : StDwell;
                StDwell: begin
                    if (expired) begin
                        state_d = StWaitWrap;
                        case (mode_q)
                            MODE_SINGLE: begin
                                if (at_stop) begin
                                    state_d = StDone;
                                end else begin
                                    k_pend_d = up_next;
                                end
                            end
                            MODE_SAW: k_pend_d = at_stop ? k_start_q : up_next;
                            default: begin
                                // Triangle: flip at a limit so the limit word is not repeated.
                                if (!dir_down_q) begin
                                    dir_down_d = at_stop;
                                    k_pend_d   = at_stop ? down_next : up_next;
                                end else begin
                                    dir_down_d = !at_start;
                                    k_pend_d   = at_start ? up_next : down_next;
                                end
                            end
                        endcase
                    end
                end
                StWaitWrap: begin
                    if (phase_wrap) begin
                        k_out_d   = k_pend_q;
                        k_valid_d = 1'b1;
                        state_d   = StDwell;
                    end
                end
                StHold:  state_d = StHold;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= MODE_SINGLE;
            fixed_q    <= 1'b0;
            k_start_q  <= '0;
            k_stop_q   <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
            k_out_q    <= '0;
            k_pend_q   <= '0;
            dir_down_q <= 1'b0;
            k_valid_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            fixed_q    <= fixed_d;
            k_start_q  <= k_start_d;
            k_stop_q   <= k_stop_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            k_out_q    <= k_out_d;
            k_pend_q   <= k_pend_d;
            dir_down_q <= dir_down_d;
            k_valid_q  <= k_valid_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        busy    = (state_q == StLoad) || (state_q == StDwell) || (state_q == StWaitWrap);
        done    = (state_q == StDone);
        k_out   = k_out_q;
        k_valid = k_valid_q;
        cfg_err = cfg_err_q;
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sequence with randomized tick/wrap/config noise,
// checked against a word-list model built from the sweep rules.
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0, phase_wrap = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  k_start = '0, k_stop = '0, step = '0;
    logic [15:0] dwell = '0;
    logic [7:0]  k_out;
    logic        k_valid, busy, done, cfg_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    dds_sweep_ctrl #(
        .W (8),
        .DW(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .phase_wrap(phase_wrap),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .k_start   (k_start),
        .k_stop    (k_stop),
        .step      (step),
        .dwell     (dwell),
        .k_out     (k_out),
        .k_valid   (k_valid),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Word list a sweep should produce, built directly from the leg/clamp rules.
    function automatic void build_seq(input int m, input int ks, input int kp, input int st,
                                      input int n);
        int v;
        bit up;
        exp_q.delete();
        v  = ks;
        up = 1'b1;
        exp_q.push_back(v);
        if (m == 0) begin
            while (v < kp) begin
                v = (v + st >= kp) ? kp : v + st;
                exp_q.push_back(v);
            end
        end else begin
            while (exp_q.size() < n) begin
                if (m == 1) begin
                    v = (v == kp) ? ks : ((v + st >= kp) ? kp : v + st);
                end else if (up) begin
                    if (v == kp) begin
                        up = 1'b0;
                        v  = (v - st <= ks) ? ks : v - st;
                    end else begin
                        v = (v + st >= kp) ? kp : v + st;
                    end
                end else begin
                    if (v == ks) begin
                        up = 1'b1;
                        v  = (v + st >= kp) ? kp : v + st;
                    end else begin
                        v = (v - st <= ks) ? ks : v - st;
                    end
                end
                exp_q.push_back(v);
            end
        end
    endfunction

    task automatic run_sweep(input logic [1:0] m, input logic [7:0] ks, input logic [7:0] kp,
                             input logic [7:0] st, input logic [15:0] dw, input int nwords,
                             input int wrap_period);
        int idx, cnt, dwn, n;
        bit ready, fin, exp_done, exp_valid, tk, wr;
        build_seq(m, ks, kp, st, nwords);
        dwn = (dw == 0) ? 1 : int'(dw);
        mode = m; k_start = ks; k_stop = kp; step = st; dwell = dw;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("load_valid", k_valid, 1);
        chk("load_word", k_out, exp_q[0]);
        chk("load_busy", busy, 1);
        chk("load_done_clr", done, 0);
        tick = 1'b0; phase_wrap = 1'b0;
        cyc();
        chk("load_gap", k_valid, 0);
        idx = 0; cnt = 0; ready = 0; fin = 0; exp_done = 0; n = 0;
        while (!fin && n < 20000) begin
            tk = ($urandom_range(0, 1) == 0);
            wr = (wrap_period == 0) ? ($urandom_range(0, 4) == 0)
                                    : ((n % wrap_period) == wrap_period - 1);
            tick = tk; phase_wrap = wr;
            // Config noise and ignored start requests while the sweep is running.
            start = ($urandom_range(0, 15) == 0);
            mode = 2'($urandom); k_start = 8'($urandom); k_stop = 8'($urandom);
            step = 8'($urandom); dwell = 16'($urandom);
            cyc();
            n++;
            exp_valid = 0;
            if (ready) begin
                if (wr) begin
                    exp_valid = 1; idx++; ready = 0; cnt = 0;
                end
            end else if (tk) begin
                cnt++;
                if (cnt == dwn) begin
                    if (m == MODE_SINGLE && idx == exp_q.size() - 1) exp_done = 1;
                    else ready = 1;
                end
            end
            chk("sweep_valid", k_valid, exp_valid);
            if (exp_valid) chk("sweep_word", k_out, exp_q[idx]);
            chk("sweep_busy", busy, !exp_done);
            chk("sweep_done", done, exp_done);
            if (exp_done || (m != MODE_SINGLE && idx == exp_q.size() - 1)) fin = 1;
        end
        start = 1'b0; tick = 1'b0; phase_wrap = 1'b0;
        chk("sweep_finished", fin, 1);
    endtask

    task automatic do_stop(input logic [7:0] kept);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_kout", k_out, kept);
        chk("stop_novalid", k_valid, 0);
    endtask

    task automatic bad_cfg(input logic [1:0] m, input logic [7:0] ks, input logic [7:0] kp,
                           input logic [7:0] st);
        bit moved;
        mode = m; k_start = ks; k_stop = kp; step = st; dwell = 16'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("bad_cfg_err", cfg_err, 1);
        chk("bad_kout", k_out, ks);
        chk("bad_valid", k_valid, 1);
        cyc();
        chk("bad_err_pulse", cfg_err, 0);
        chk("bad_hold_busy", busy, 0);
        moved = 0;
        for (int i = 0; i < 40; i++) begin
            tick = 1'b1; phase_wrap = ($urandom_range(0, 2) == 0);
            cyc();
            if (k_valid !== 1'b0 || k_out !== ks || busy !== 1'b0) moved = 1;
        end
        tick = 1'b0; phase_wrap = 1'b0;
        chk("bad_hold_stable", moved, 0);
        do_stop(ks);
    endtask

    initial begin
        bit moved;
        cyc();
        chk("rst_kout", k_out, 0);
        chk("rst_valid", k_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        cyc();

        // Fixed mode: load once, then hold through 1000 ticks and ignored starts.
        mode = MODE_FIXED; k_start = 8'h20; k_stop = 8'h00; step = 8'h00; dwell = 16'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("fixed_kout", k_out, 8'h20);
        chk("fixed_valid", k_valid, 1);
        chk("fixed_no_err", cfg_err, 0);
        cyc();
        chk("fixed_valid_pulse", k_valid, 0);
        moved = 0;
        for (int i = 0; i < 2000; i++) begin
            tick = (i % 2 == 0); phase_wrap = ($urandom_range(0, 6) == 0);
            start = (i == 999); k_start = 8'h55;
            cyc();
            if (k_valid !== 1'b0 || k_out !== 8'h20 || busy !== 1'b0) moved = 1;
        end
        tick = 1'b0; phase_wrap = 1'b0; start = 1'b0;
        chk("fixed_hold_stable", moved, 0);
        do_stop(8'h20);

        run_sweep(MODE_SINGLE, 8'd10, 8'd40, 8'd10, 16'd3, 0, 7);
        chk("single_final", k_out, 8'd40);
        do_stop(8'd40);

        // start and stop together in IDLE: stop wins.
        mode = MODE_SINGLE; k_start = 8'd1; k_stop = 8'd9; step = 8'd1;
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_valid", k_valid, 0);
        chk("startstop_kout", k_out, 8'd40);

        run_sweep(MODE_TRI, 8'd5, 8'd17, 8'd5, 16'($urandom_range(0, 3)), 10, 0);
        do_stop(8'(exp_q[exp_q.size() - 1]));
        run_sweep(MODE_SAW, 8'd250, 8'd255, 8'd4, 16'd2, 7, 0);
        do_stop(8'(exp_q[exp_q.size() - 1]));
        for (int r = 0; r < 3; r++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 200));
            b = a + 8'($urandom_range(1, 55));
            run_sweep(2'($urandom_range(0, 2)), a, b, 8'($urandom_range(1, 30)),
                      16'($urandom_range(0, 4)), 9, 0);
            do_stop(8'(exp_q[exp_q.size() - 1]));
        end

        bad_cfg(MODE_SINGLE, 8'd8, 8'd8, 8'd1);
        bad_cfg(MODE_TRI, 8'd3, 8'd9, 8'd0);
        bad_cfg(MODE_SAW, 8'd30, 8'd12, 8'd4);

        // Reset while waiting for a wrap clears the output at once.
        mode = MODE_SINGLE; k_start = 8'd10; k_stop = 8'd40; step = 8'd10; dwell = 16'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("ww_busy", busy, 1);
        chk("ww_kout", k_out, 8'd10);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_kout", k_out, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", k_valid, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
